// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types and constants for the seven-segment display arbiter
//
// Purpose: holds the arbiter state enum, the requester count and a one-hot
//          helper used by the top level.
// Contents: N_REQ, state_e, onehot()
package sseg_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SWITCH
  } state_e;

  // Requester index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational three-way round-robin pick
//
// Purpose: finds the first set request bit starting one past the last owner
//          and wrapping, so the last owner itself is the final candidate.
// Ports:
//   req  [2:0] in  - request vector
//   last [1:0] in  - previous owner index
//   pick [1:0] out - chosen requester index (0 when any is low)
//   any        out - at least one request bit is set
module rr_pick3
  import sseg_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       pick,
  output logic             any
);

  logic [1:0] idx;

  // Walk candidates from farthest to nearest so the nearest set bit is the
  // last assignment and therefore wins.
  always_comb begin
    pick = 2'd0;
    idx  = 2'd0;
    any  = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = 2'((int'(last) + i) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/sseg_disp_arbiter.sv
// rtl/sseg_disp_arbiter.sv - round-robin owner arbiter for a shared seven-segment display
//
// Purpose: grants the display to one of three requesters, keeps the owner for
//          at least HOLD cycles while it still requests, and inserts one idle
//          cycle between owners.
// Ports:
//   clk            in  - system clock, rising edge
//   rst            in  - asynchronous active-low reset
//   req   [2:0]    in  - level-sensitive requests, bit i = requester i
//   data0..2[31:0] in  - eight BCD nibbles per requester, nibble k = digit k
//   grant [2:0]    out - registered one-hot or zero ownership
//   disp_en        out - registered, high while grant is nonzero
//   disp_data[31:0]out - owner's data, zero with no owner
module sseg_disp_arbiter
  import sseg_pkg::*;
#(
  parameter int HOLD = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [31:0]      data0,
  input  logic [31:0]      data1,
  input  logic [31:0]      data2,
  output logic [N_REQ-1:0] grant,
  output logic             disp_en,
  output logic [31:0]      disp_data
);

  localparam int CNT_W = $clog2(HOLD);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               disp_en_q, disp_en_d;
  logic [1:0]         last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [1:0]         pick;
  logic               any_req;
  logic [N_REQ-1:0]   others;
  logic               owner_req;
  logic               hold_done;

  rr_pick3 u_pick (
    .req  (req),
    .last (last_owner_q),
    .pick (pick),
    .any  (any_req)
  );

  // While granted, grant_q is the owner's one-hot, so it masks the owner out.
  assign others    = req & ~grant_q;
  assign owner_req = |(req & grant_q);
  assign hold_done = (hold_cnt_q == CNT_W'(HOLD - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    unique case (state_q)
      IDLE, SWITCH: begin
        // SWITCH is always a single cycle; with no requests both fall to IDLE.
        grant_d    = '0;
        hold_cnt_d = '0;
        state_d    = IDLE;
        if (any_req) begin
          state_d      = GRANT;
          grant_d      = onehot(pick);
          last_owner_d = pick;
        end
      end
      GRANT: begin
        // An owner dropping its request leaves regardless of hold_done.
        if (!owner_req || (hold_done && (|others))) begin
          grant_d    = '0;
          hold_cnt_d = '0;
          state_d    = (|others) ? SWITCH : IDLE;
        end else if (!hold_done) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    disp_en_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      disp_en_q    <= 1'b0;
      last_owner_q <= 2'd2;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      disp_en_q    <= disp_en_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign disp_en = disp_en_q;

  // Straight nibble-for-nibble pass of the owner's word to the digit inputs.
  always_comb begin
    disp_data = 32'h0;
    case (grant_q)
      3'b001:  disp_data = data0;
      3'b010:  disp_data = data1;
      3'b100:  disp_data = data2;
      default: disp_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// tb/tb_sseg_disp_arbiter.sv - scoreboard bench for sseg_disp_arbiter with a behavioural model
module tb_sseg_disp_arbiter;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [31:0] data0, data1, data2;
  logic [2:0]  grant;
  logic        disp_en;
  logic [31:0] disp_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [35:0] exp_q[$];

  // Behavioural model: who owns the display, for how long, and whether a
  // one-cycle blank gap is due before the next owner.
  int m_owner;
  int m_owned;
  int m_last;
  bit m_gap;

  sseg_disp_arbiter #(.HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .grant     (grant),
    .disp_en   (disp_en),
    .disp_data (disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rr(input logic [2:0] r, input int last);
    int idx;
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_owned = 0;
    m_last  = 2;
    m_gap   = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] r, input bit rv);
    logic [2:0] others;
    if (!rv) begin
      model_reset();
    end else if (m_gap || m_owner < 0) begin
      m_gap   = 1'b0;
      m_owner = rr(r, m_last);
      m_owned = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else begin
      others = r & ~(3'b001 << m_owner);
      if (!r[m_owner[1:0]] || (m_owned >= HOLD && others != 3'b000)) begin
        m_gap   = (others != 3'b000);
        m_owner = -1;
      end else begin
        m_owned++;
      end
    end
  endtask

  function automatic logic [35:0] model_out();
    logic [2:0]  g;
    logic [31:0] d;
    g = 3'b000;
    d = 32'h0;
    if (m_owner == 0) begin g = 3'b001; d = data0; end
    if (m_owner == 1) begin g = 3'b010; d = data1; end
    if (m_owner == 2) begin g = 3'b100; d = data2; end
    return {g, (g != 3'b000), d};
  endfunction

  // One clock of stimulus: inputs change on the falling edge, the model
  // advances to what the next rising edge should produce.
  task automatic cycle(input logic [2:0] r, input bit rv);
    @(negedge clk);
    rst   = rv;
    req   = r;
    data0 = $urandom;
    data1 = $urandom;
    data2 = $urandom;
    model_step(r, rv);
    exp_q.push_back(model_out());
  endtask

  task automatic repeat_cycles(input logic [2:0] r, input int n);
    for (int i = 0; i < n; i++) cycle(r, 1'b1);
  endtask

  task automatic check_reset_now(input string name);
    checks++;
    if (grant !== 3'b000 || disp_en !== 1'b0 || disp_data !== 32'h0) begin
      errors++;
      $display("FAIL %s: got grant=%b en=%b data=%h, required 000/0/00000000",
               name, grant, disp_en, disp_data);
    end
  endtask

  // Pull rst low between clock edges and confirm outputs clear immediately.
  task automatic reset_pulse(input logic [2:0] r_during, input int n_low);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_reset_now("async_reset");
    model_reset();
    for (int i = 0; i < n_low; i++) cycle(r_during, 1'b0);
  endtask

  always @(posedge clk) begin
    logic [35:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({grant, disp_en, disp_data} !== e) begin
        errors++;
        $display("FAIL cycle%0d: got grant=%b en=%b data=%h, required grant=%b en=%b data=%h",
                 cyc, grant, disp_en, disp_data, e[35:33], e[32], e[31:0]);
      end
    end
    cyc++;
  end

  initial begin
    rst   = 1'b0;
    req   = 3'b111;
    data0 = 32'h0;
    data1 = 32'h0;
    data2 = 32'h0;
    model_reset();
    #1 check_reset_now("reset_initial");

    // Reset held with all requesting, then released: requester 0 first.
    for (int i = 0; i < 3; i++) cycle(3'b111, 1'b0);
    repeat_cycles(3'b111, 3);

    // Rotation between two requesters.
    repeat_cycles(3'b000, 2);
    repeat_cycles(3'b011, 16);

    // Single requester keeps its grant.
    repeat_cycles(3'b000, 2);
    repeat_cycles(3'b010, 22);

    // Early drop: owner 1 for one cycle, then only requester 2.
    repeat_cycles(3'b000, 2);
    repeat_cycles(3'b010, 1);
    repeat_cycles(3'b100, 4);

    // All drop, then everyone requests.
    repeat_cycles(3'b000, 2);
    repeat_cycles(3'b001, 2);
    repeat_cycles(3'b000, 2);
    repeat_cycles(3'b111, 3);

    // Lone previous owner across a switch, and owner drop racing others.
    repeat_cycles(3'b000, 2);
    repeat_cycles(3'b101, 5);
    repeat_cycles(3'b100, 3);
    repeat_cycles(3'b010, 3);

    // Mid-grant reset while requester 2 owns.
    repeat_cycles(3'b000, 2);
    repeat_cycles(3'b100, 2);
    reset_pulse(3'b111, 2);
    repeat_cycles(3'b111, 3);

    // Randomised traffic with sticky requests and occasional resets.
    begin
      logic [2:0] r;
      r = 3'b000;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 249) == 0) reset_pulse(r, $urandom_range(1, 2));
        else cycle(r, 1'b1);
      end
    end

    @(posedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
